// File: rtl/rom_burst_reader.sv
// rom_burst_reader: burst read initiator for one port of the synchronous
// dual-port ROM. Accepts (address, length) requests, issues ROM reads
// while absorbing the one-cycle read latency, and streams the words out
// on a valid/ready interface through a 3-entry buffer.
// Optional feature macro: ROM_READER_WRAP_EN (address wraps at the end of
// the ROM and the full saturated length is read).
module rom_burst_reader #(
  parameter int size  = 2048,
  parameter int width = 16,
  parameter int asize = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [asize-1:0] req_addr,
  input  logic [asize:0]   req_len,
  output logic             rom_en,
  output logic [asize-1:0] rom_addr,
  input  logic [width-1:0] rom_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int DEPTH = 3;
  localparam logic [asize:0] SIZE_W = (asize+1)'(size);
  localparam logic [asize:0] ONE_L  = (asize+1)'(1);
`ifdef ROM_READER_WRAP_EN
  localparam logic [asize-1:0] LAST_ADDR = asize'(size - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [asize-1:0] r_addr;
  logic [asize:0]   r_remain;
  logic             r_infl;
  logic             r_infl_last;
  logic [width-1:0] r_fifo_data [DEPTH];
  logic             r_fifo_last [DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_count;

  logic             w_req_ready;
  logic             w_rom_en;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_next;
  logic [asize:0]   w_len_sat;
  logic [asize:0]   w_room;
  logic [asize:0]   w_eff_len;
  logic [asize-1:0] w_addr_next;

  // Effective burst length: saturate to the ROM depth, zero for an
  // out-of-range start address, and optionally truncate at the ROM end.
  always_comb begin
    w_len_sat = (req_len > SIZE_W) ? SIZE_W : req_len;
    w_room    = SIZE_W - {1'b0, req_addr};
    w_eff_len = '0;
    if ({1'b0, req_addr} < SIZE_W) begin
`ifdef ROM_READER_WRAP_EN
      w_eff_len = w_len_sat;
`else
      w_eff_len = (w_len_sat < w_room) ? w_len_sat : w_room;
`endif
    end
  end

  // Next read address, wrapping at the last ROM word when enabled.
  always_comb begin
`ifdef ROM_READER_WRAP_EN
    w_addr_next = (r_addr == LAST_ADDR) ? '0 : r_addr + asize'(1);
`else
    w_addr_next = r_addr + asize'(1);
`endif
  end

  // Buffer occupancy bookkeeping: a read in flight always lands one cycle
  // later, so the issue rule counts it against the free space.
  assign w_push       = r_infl;
  assign w_pop        = (r_count != 2'd0) && out_ready;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and registered-only ROM issue decision.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_rom_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid && (w_eff_len != '0)) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_rom_en = (({1'b0, r_count} + {2'b00, r_infl}) <= 3'd2);
        if (w_rom_en && (r_remain == ONE_L)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_infl && (w_count_next == 2'd0)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request capture, address/length counters, in-flight tracking and FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remain    <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_req_ready && req_valid) begin
        r_addr   <= req_addr;
        r_remain <= w_eff_len;
      end else if (w_rom_en) begin
        r_addr   <= w_addr_next;
        r_remain <= r_remain - ONE_L;
      end
      r_infl      <= w_rom_en;
      r_infl_last <= w_rom_en && (r_remain == ONE_L);
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= rom_dout;
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      r_count <= w_count_next;
    end
  end

  assign req_ready = w_req_ready;
  assign busy      = !w_req_ready;
  assign rom_en    = w_rom_en;
  assign rom_addr  = r_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed bench for rom_burst_reader with a behavioural
// ROM (data = address) and a scoreboard of expected words and read addresses.
module tb_rom_burst_reader;

  localparam int SIZE = 2048;
  localparam int W    = 16;
  localparam int AW   = 11;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW:0]   req_len;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_dout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  logic [W:0] data_q [$];
  int         addr_q [$];

  rom_burst_reader #(.size(SIZE), .width(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with one-cycle registered read; each word holds its own address.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= W'(rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_rom_en"},    32'(rom_en),    0);
    chk({tag, "_rom_addr"},  32'(rom_addr),  0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_out_last"},  32'(out_last),  0);
  endtask

  // mode 0: out_ready held high; mode 1: random with a 10-cycle stall.
  // abort_after > 0: assert reset right after that many words were taken.
  task automatic do_burst(input int addr, input int len, input int mode, input int abort_after);
    int eff, sat, cyc, pops, outstanding, first_valid, waitc;
    bit done, prev_stall, prev_l;
    logic [W-1:0] prev_d;
    logic [W:0] exp_w;
    sat = (len > SIZE) ? SIZE : len;
    if (addr >= SIZE) eff = 0;
    else begin
`ifdef ROM_READER_WRAP_EN
      eff = sat;
`else
      eff = (sat < SIZE - addr) ? sat : SIZE - addr;
`endif
    end
    for (int i = 0; i < eff; i++) begin
      data_q.push_back({(i == eff - 1), W'((addr + i) % SIZE)});
      addr_q.push_back((addr + i) % SIZE);
    end
    $display("request addr=%0d len=%0d effective=%0d mode=%0d", addr, len, eff, mode);
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_len   = (AW+1)'(len);
    out_ready = (mode == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (eff == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("zero_len_rom_en", 32'(rom_en), 0);
        chk("zero_len_out_valid", 32'(out_valid), 0);
        chk("zero_len_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
      end
      return;
    end
    cyc = 0; pops = 0; outstanding = 0; first_valid = -1;
    done = 1'b0; prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0;
    while (!done && cyc < 6000) begin
      if (mode == 1) out_ready = (cyc >= 4 && cyc < 14) ? 1'b0 : 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      if (cyc == 0) chk("first_rom_en", 32'(rom_en), 1);
      if (rom_en) begin
        if (addr_q.size() == 0) chk("extra_issue", 1, 0);
        else chk("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
        chk("issue_while_full", 32'(outstanding > 2), 0);
        outstanding++;
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        if (mode == 0) chk("first_valid_cycle", 32'(cyc), 2);
      end
      if (mode == 0 && first_valid >= 0 && data_q.size() > 0)
        chk("throughput_valid", 32'(out_valid), 1);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(prev_d));
        chk("stall_last", 32'(out_last), 32'(prev_l));
      end
      if (out_valid && out_ready) begin
        if (data_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          exp_w = data_q.pop_front();
          chk("out_data", 32'(out_data), 32'(exp_w[W-1:0]));
          chk("out_last", 32'(out_last), 32'(exp_w[W]));
        end
        outstanding--;
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && pops == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        data_q.delete();
        addr_q.delete();
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("burst aborted by reset after %0d words", pops);
        return;
      end
      if (data_q.size() == 0 && pops == eff) begin
        chk("done_req_ready", 32'(req_ready), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_addr_q_empty", 32'(addr_q.size()), 0);
        done = 1'b1;
      end
    end
    if (!done) chk("burst_timeout", 0, 1);
    $display("burst addr=%0d done: %0d words in %0d cycles", addr, pops, cyc);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_burst(0, 0, 0, 0);        // zero length: no access, no output
    do_burst(5, 4, 0, 0);        // basic burst
    do_burst(0, 16, 1, 0);       // backpressure
    do_burst(2046, 4, 0, 0);     // end of ROM (wrap or truncate)
    do_burst(0, 4095, 0, 0);     // length saturation
    do_burst(0, 10, 0, 3);       // reset after 3 words
    do_burst(100, 2, 0, 0);      // recovery burst after reset

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
